cosine_job_sequencer: RTL
=========================

# cosine_job_sequencer

Host-side initiator for the cosine/distance engine (`controlUnit` + `datapath`), which computes `distance` from a velocity `v` and an angle `x`. It accepts (v, x) jobs from a host through a valid/ready port and buffers them in a small FIFO. It runs each job on the engine with a clear/start/done handshake and returns each distance, tagged, through a valid/ready result port. The engine itself is unchanged; this block sits between the host and the engine.

## Interface

Parameters:
- `DEPTH`, 4: job FIFO entries; power of two, 2 to 16.
- `TIMEOUT`, 64: maximum WAIT cycles per job, 2 to 255; used only with `COS_SEQ_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `job_valid` input 1: host offers a job.
- `job_ready` output 1: FIFO not full; equals `!full`, with no same-cycle bypass.
- `job_v` input 16: velocity, signed Q5.11.
- `job_x` input 16: angle, signed Q5.11.
- `eng_rst` output 1: engine reset.
- `eng_start` output 1: engine start pulse.
- `eng_v` output 16: engine `vSig` operand.
- `eng_x` output 16: engine `XSig` operand.
- `eng_done` input 1: engine `done`; only its rising edge is used.
- `eng_distance` input 16: engine `distance`, signed Q5.11.
- `res_valid` output 1: result register is full.
- `res_ready` input 1: host accepts the result.
- `res_distance` output 16: distance, Q5.11.
- `res_tag` output 4: job sequence number.
- `res_err` output 1: the job timed out.
- `busy` output 1: state is not IDLE, or the FIFO is not empty.

## Operation

- The job FIFO holds {v, x} pairs.
  - A push happens when `job_valid && job_ready`.
  - A pop happens on the IDLE→CLEAR transition.
  - When full, `job_ready` is 0 and the push is refused even if a pop occurs in the same cycle.
- The state register is 3 bits, with these states:
  - IDLE: if the FIFO is not empty, pop the head into the operand registers `eng_v`/`eng_x` and go to CLEAR.
  - CLEAR: `eng_rst`=1 for exactly 1 cycle. Go to LAUNCH.
  - LAUNCH: `eng_start`=1 for exactly 1 cycle. Clear the wait counter. Go to WAIT.
  - WAIT: the wait counter increments each cycle.
    - On a rising edge of `eng_done` (`eng_done && !done_q`), capture `eng_distance` into the hold register, set err=0, and go to STORE.
    - With `COS_SEQ_TIMEOUT_EN` defined, if the counter reaches `TIMEOUT-1` first, set hold=0 and err=1, then go to STORE.
  - STORE: if `!res_valid || res_ready`:
    - load `res_distance`/`res_err` from hold and `res_tag` from the tag counter;
    - set `res_valid`;
    - increment the tag counter (mod 16, 15→0 wraps);
    - go to IDLE.
    - Otherwise stay in STORE with hold unchanged (back-pressure).
- `eng_v`/`eng_x` stay stable from CLEAR until the next pop.
- `done_q` is a registered copy of `eng_done`, updated every cycle. Outside WAIT, `eng_done` edges are ignored; this covers stale or high `done` levels during CLEAR and LAUNCH.
- Results pass through unmodified; the block does no arithmetic on the Q5.11 data.
- Reset:
  - `rst` forces `eng_rst`=1 combinationally (`eng_rst` = `rst` OR CLEAR).
  - All registers are cleared: the FIFO is emptied and in-flight and queued jobs are discarded.

## Timing

- Reset values:
  - `job_ready`=1, `eng_start`=0, `eng_v`=0, `eng_x`=0, `res_valid`=0, `res_distance`=0, `res_tag`=0, `res_err`=0, `busy`=0.
  - `eng_rst`=1 while `rst` is high and 0 after release.
- Latency (idle block, empty FIFO):
  - Job accepted at edge N.
  - CLEAR during cycle N+1.
  - LAUNCH during cycle N+2.
  - WAIT from cycle N+3.
- Done rising edge seen in WAIT at edge D: STORE in cycle D+1, `res_valid`=1 from edge D+2 (when not back-pressured).
- Back-to-back jobs: the next CLEAR starts 1 cycle after STORE exits (one IDLE cycle).
- `res_valid`/`res_tag`/`res_distance` hold steady until `res_ready` is sampled high. A same-cycle accept and reload is allowed.
- Asserting `rst` mid-WAIT aborts the job. No result is emitted, and the tag counter restarts at 0.

## Configuration

- `COS_SEQ_TIMEOUT_EN` defined:
  - a watchdog counter (8 bits) is built;
  - a job stuck in WAIT for `TIMEOUT` cycles produces `res_err`=1 and `res_distance`=0, consumes a tag, and the sequencer continues with the next job.
- Undefined:
  - no counter is built;
  - WAIT exits only on a `done` edge, so the block waits forever if `done` never rises;
  - `res_err` is tied to 0.

## Test plan

- Push v=`16'h0800` (1.0), x=`16'h0400` (0.5); the engine model asserts done after 12 cycles with distance=`16'h0705`. Expect:
  - `eng_rst` pulse 1 cycle, then `eng_start` 1 cycle;
  - `res_valid` with `res_distance`=`16'h0705`, `res_tag`=0, `res_err`=0, 2 cycles after the done edge.
- Push 5 jobs back-to-back with `DEPTH`=4 while the engine is busy. Expect:
  - `job_ready` drops after the 5th accepted push (1 job in flight plus 4 queued);
  - results come out in push order with tags 0–4.
- Hold `res_ready`=0 across 2 completed jobs. Expect:
  - the first result is held stable and the sequencer stalls in STORE;
  - on `res_ready`=1 for 1 cycle, the second result (tag 1) appears on the next cycle.
- Hold `eng_done` high through CLEAR and LAUNCH, then drop it and raise it again in WAIT. Expect only the WAIT rising edge to complete the job.
- With `COS_SEQ_TIMEOUT_EN` and `TIMEOUT`=16, the engine never signals done. Expect:
  - `res_err`=1 and `res_distance`=0 after 16 WAIT cycles;
  - the next queued job then runs normally with tag+1.
- Assert `rst` mid-WAIT with 2 jobs queued. Expect:
  - `eng_rst` high immediately;
  - no result emitted, FIFO empty, and `busy`=0 after release;
  - the next job returns `res_tag`=0.

Source files
------------

// File: rtl/cosine_job_sequencer.sv
// cosine_job_sequencer: queues (v, x) jobs from a host, runs each one on the
// cosine/distance engine with a clear/start/done handshake, and returns the
// tagged distance through a one-entry result register.
// Optional build macro: COS_SEQ_TIMEOUT_EN adds a WAIT watchdog that turns a
// job whose done never rises into an error result (res_err=1, distance=0).
module cosine_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic signed [15:0] job_v,
    input  logic signed [15:0] job_x,
    output logic               eng_rst,
    output logic               eng_start,
    output logic signed [15:0] eng_v,
    output logic signed [15:0] eng_x,
    input  logic               eng_done,
    input  logic signed [15:0] eng_distance,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [15:0] res_distance,
    output logic [3:0]         res_tag,
    output logic               res_err,
    output logic               busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        STORE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic signed [15:0] fifo_v [DEPTH];
    logic signed [15:0] fifo_x [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               done_q;
    logic               done_rise;
    logic               timeout_hit;
    logic               store_fire;
    logic signed [15:0] hold_distance;
    logic [3:0]         tag;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign job_ready = !full;
    assign push      = job_valid && !full;
    assign done_rise = eng_done && !done_q;
    assign eng_rst   = rst || (state == CLEAR);
    assign eng_start = (state == LAUNCH);
    assign busy      = (state != IDLE) || !empty;

    // Job storage; contents are meaningless once the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_v[wr_ptr] <= job_v;
            fifo_x[wr_ptr] <= job_x;
        end
    end

    // FIFO pointers and occupancy; a pop never frees room for a same-cycle push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic plus the pop and result-load strobes.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        store_fire = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR:  state_next = LAUNCH;
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (done_rise || timeout_hit) state_next = STORE;
            end
            STORE: begin
                if (!res_valid || res_ready) begin
                    store_fire = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands stay put from the pop until the next job is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_v <= '0;
            eng_x <= '0;
        end else if (pop) begin
            eng_v <= fifo_v[rd_ptr];
            eng_x <= fifo_x[rd_ptr];
        end
    end

    // Delayed copy of done so only a rising edge inside WAIT completes a job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= eng_done;
    end

    // Hold register: engine distance on done, zero on a watchdog expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_distance <= '0;
        end else if (state == WAIT) begin
            if (done_rise)        hold_distance <= eng_distance;
            else if (timeout_hit) hold_distance <= '0;
        end
    end

`ifdef COS_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       hold_err;

    assign timeout_hit = (state == WAIT) && !done_rise && (wait_cnt == 8'(TIMEOUT - 1));

    // Watchdog: cleared at launch, counts every WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wait_cnt <= '0;
        else if (state == LAUNCH) wait_cnt <= '0;
        else if (state == WAIT)   wait_cnt <= wait_cnt + 8'd1;
    end

    // Error flag travels with the held distance into the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_err <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            if (state == WAIT) begin
                if (done_rise)        hold_err <= 1'b0;
                else if (timeout_hit) hold_err <= 1'b1;
            end
            if (store_fire) res_err <= hold_err;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign res_err     = 1'b0;
`endif

    // Result register: loads when empty or being drained in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_distance <= '0;
            res_tag      <= '0;
            tag          <= '0;
        end else begin
            if (store_fire) begin
                res_valid    <= 1'b1;
                res_distance <= hold_distance;
                res_tag      <= tag;
                tag          <= tag + 4'd1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
